m_seven_segment_scan: RTL and testbench
=======================================

M_SEVEN_SEGMENT_SCAN -- requirements
Module: m_seven_segment_scan

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CLK_DIV, 50000, clocks per digit slot, minimum 4.
- BLANK_CYC, 2, clocks of all-digits-off at slot start, must be < CLK_DIV.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, scan enable.
- load, in, 1, capture data_in/dot_in into shadow this cycle.
- data_in, in, 16, four hex digits; digit k = data_in[4k+3:4k], digit 0 rightmost.
- dot_in, in, 4, per-digit decimal point, 1 = lit.
- blank_lz, in, 1, leading-zero blanking enable.
- seg, out, 8, active-low segments; bit7 = dp, bits6:0 = g..a.
- digit_sel, out, 4, active-low digit enables; bit k = digit k.
- pending, out, 1, shadow holds data not yet displayed.
- frame_start, out, 1, one-cycle pulse when active data is refreshed.
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low; all flops SHALL reset on rst_n low regardless of clk.

Function
REQ-004 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL assert when count == CLK_DIV-1 and enable = 1.
REQ-005 Digit index (2 bits) SHALL advance 0->1->2->3->0 on each tick; no other transitions.
REQ-006 While enable = 0:
- prescaler and index SHALL hold;
- digit_sel SHALL be 4'b1111 and seg 8'hFF on the next clock;
- load SHALL still be accepted.
REQ-007 Within a slot, for prescaler values 0..BLANK_CYC-1, digit_sel SHALL be 4'b1111 (anti-ghosting); otherwise exactly bit [index] SHALL be 0.
REQ-008 seg SHALL be the standard hex glyph (0-F, active-low, dp bit 1) of the active nibble for the current index, ANDed with dp low when the active dot bit is set.
REQ-009 seg and digit_sel SHALL be registered; they reflect prescaler/index state with exactly one clock latency.
REQ-010 Leading-zero blanking: when blank_lz = 1, digit k (k = 3, 2, 1) SHALL output seg 8'hFF if active nibbles k..3 are all zero and its dot is clear; digit 0 SHALL never be blanked.
REQ-011 load = 1 SHALL write data_in and dot_in into the shadow registers and set pending on the next edge; consecutive loads overwrite, last wins.
REQ-012 Frame wrap is a tick with index = 3. At wrap with pending = 1, active <= shadow, pending <= 0, and frame_start SHALL pulse for one cycle. At wrap with pending = 0, nothing is copied and there is no pulse.
REQ-013 Active data SHALL never change mid-frame (no tearing).
REQ-014 If load and a wrap occur in the same cycle, active SHALL take the prior shadow, the shadow takes the new data, and pending SHALL remain 1.

Reset
REQ-015 While rst_n = 0, outputs SHALL be:
- seg = 8'hFF, digit_sel = 4'b1111, pending = 0, frame_start = 0;
- prescaler = 0, index = 0, shadow = 0, active = 0, dots = 0.
REQ-016 Reset asserted mid-frame SHALL discard pending data. After release, scanning SHALL resume from index 0, prescaler 0, on the first clock with enable = 1.

Verification (CLK_DIV = 4, BLANK_CYC = 1)
REQ-017 Basic scan:
- Stimulus: reset, enable = 1, load data_in = 16'h1234 once, wait one frame.
- Required response: next frame digit_sel cycles 1110, 1101, 1011, 0111; seg shows 4 = 8'h99, 3 = 8'hB0, 2 = 8'hA4, 1 = 8'hF9; each slot has 1 cycle of 1111 then 3 cycles active.
REQ-018 No-tearing handshake:
- Stimulus: load 16'hAAAA mid-frame while 16'h1234 is displayed.
- Required response: pending = 1, remaining digits still show 1234; at wrap frame_start pulses, pending = 0, and the next frame shows seg 8'h88 on all digits.
REQ-019 Simultaneous load and wrap:
- Stimulus: load 16'h5555 exactly on the wrap cycle, with shadow = 16'h0F0F and pending = 1.
- Required response: next frame shows 0F0F; pending stays 1; the following frame shows 5555.
REQ-020 Leading-zero blanking and dots:
- Stimulus: blank_lz = 1, data 16'h0050, dot_in = 4'b0100.
- Required response: digit 3 = 8'hFF; digit 2 = 8'h40 (0 with dp); digit 1 = 8'h92; digit 0 = 8'hC0.
- Stimulus: data 16'h0000.
- Required response: only digit 0 is lit, with 8'hC0.
REQ-021 Enable and reset:
- Stimulus: enable = 0 mid-slot.
- Required response: outputs go 1111/FF next clock, and index is held.
- Stimulus: assert rst_n low asynchronously mid-frame with pending = 1.
- Required response: immediately seg = 8'hFF, digit_sel = 1111, pending = 0; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/m_seven_segment_scan.sv
// ---------------------------------------------------------------------------
// m_seven_segment_scan
//
// Purpose:
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   Each digit gets a slot of CLK_DIV clocks. The first BLANK_CYC clocks of
//   every slot turn all digits off so the previous digit's pattern cannot
//   ghost onto the next one. New data is captured into a shadow register and
//   is only promoted to the displayed ("active") register at a frame wrap.
//   A frame is never torn as a result.
//
// Parameters:
//   CLK_DIV    clocks per digit slot (minimum 4)
//   BLANK_CYC  clocks of all-digits-off at the start of each slot (< CLK_DIV)
//
// Ports:
//   clk          single clock
//   rst_n        asynchronous active-low reset
//   enable       scan enable; when low the display is dark and scanning holds
//   load         capture data_in/dot_in into the shadow this cycle
//   data_in      four hex digits, digit k = data_in[4k+3:4k], digit 0 rightmost
//   dot_in       per-digit decimal point, 1 = lit
//   blank_lz     leading-zero blanking enable
//   seg          active-low segments, bit7 = dp, bits6:0 = g..a (registered)
//   digit_sel    active-low digit enables, bit k = digit k (registered)
//   pending      shadow holds data that has not been displayed yet
//   frame_start  one-cycle pulse when the active data is refreshed
// ---------------------------------------------------------------------------
module m_seven_segment_scan #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  dot_in,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [3:0]  digit_sel,
    output logic        pending,
    output logic        frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_dot_q, shadow_dot_d;
    logic [15:0]   active_q, active_d;
    logic [3:0]    active_dot_q, active_dot_d;
    logic          pending_q, pending_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    digit_sel_q, digit_sel_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    cur_nibble;
    logic          cur_dot;
    logic          cur_lz;
    logic          zero_3, zero_32, zero_321;

    // Active-low hex glyphs, gfedcba in bits 6:0, dp (bit 7) off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign tick = enable && (presc_q == PRESC_LAST);
    assign wrap = tick && (idx_q == 2'd3);

    // Prescaler and digit index; both freeze while the scan is disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Shadow/active handshake. At a wrap the active copy takes the shadow
    // value from before this edge. A load on the same edge therefore lands
    // in the shadow and stays pending for the following frame.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_dot_d  = shadow_dot_q;
        active_d      = active_q;
        active_dot_d  = active_dot_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        if (wrap && pending_q) begin
            active_d      = shadow_q;
            active_dot_d  = shadow_dot_q;
            pending_d     = 1'b0;
            frame_start_d = 1'b1;
        end
        if (load) begin
            shadow_d     = data_in;
            shadow_dot_d = dot_in;
            pending_d    = 1'b1;
        end
    end

    // Digit k is a leading zero when active nibbles k..3 are all zero.
    always_comb begin
        zero_3   = (active_q[15:12] == 4'h0);
        zero_32  = zero_3  && (active_q[11:8] == 4'h0);
        zero_321 = zero_32 && (active_q[7:4]  == 4'h0);
        case (idx_q)
            2'd0: begin
                cur_nibble = active_q[3:0];
                cur_dot    = active_dot_q[0];
                cur_lz     = 1'b0;
            end
            2'd1: begin
                cur_nibble = active_q[7:4];
                cur_dot    = active_dot_q[1];
                cur_lz     = zero_321;
            end
            2'd2: begin
                cur_nibble = active_q[11:8];
                cur_dot    = active_dot_q[2];
                cur_lz     = zero_32;
            end
            default: begin
                cur_nibble = active_q[15:12];
                cur_dot    = active_dot_q[3];
                cur_lz     = zero_3;
            end
        endcase
    end

    // Output pattern for the current prescaler/index state. It is registered
    // below, so the pins lag the scan state by exactly one clock.
    always_comb begin
        seg_d       = 8'hFF;
        digit_sel_d = 4'b1111;
        if (enable) begin
            if (presc_q >= BLANK_END) begin
                digit_sel_d[idx_q] = 1'b0;
            end
            if (blank_lz && cur_lz && !cur_dot) begin
                seg_d = 8'hFF;
            end else begin
                seg_d = hex_glyph(cur_nibble);
                if (cur_dot) begin
                    seg_d[7] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            shadow_q      <= 16'h0000;
            shadow_dot_q  <= 4'h0;
            active_q      <= 16'h0000;
            active_dot_q  <= 4'h0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= 8'hFF;
            digit_sel_q   <= 4'b1111;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            shadow_dot_q  <= shadow_dot_d;
            active_q      <= active_d;
            active_dot_q  <= active_dot_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    assign seg         = seg_q;
    assign digit_sel   = digit_sel_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_m_seven_segment_scan.sv
// ---------------------------------------------------------------------------
// tb_m_seven_segment_scan
//
// Directed bench for the seven-segment scanner with CLK_DIV = 4 and
// BLANK_CYC = 1. This makes one frame 16 clocks: four slots, each with one
// dark clock and three lit clocks. Inputs change 1 time unit after the
// rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_m_seven_segment_scan;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic [3:0]  dot_in   = 4'h0;
    logic        blank_lz = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  digit_sel;
    logic        pending;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    m_seven_segment_scan #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .data_in     (data_in),
        .dot_in      (dot_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .digit_sel   (digit_sel),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Hard time limit in case the scan never produces what is expected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic l, input logic [15:0] d, input logic [3:0] dt);
        load    = l;
        data_in = d;
        dot_in  = dt;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Runs one full frame starting right after a wrap edge, checking every
    // cycle. e0..e3 are the expected lit patterns of digits 0..3. A load is
    // issued before step load_at (-1 = none); load_at = 15 hits the wrap edge.
    task automatic runFrame(input string name,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input int load_at, input logic [15:0] ld,
                            input logic [3:0] ldot);
        logic [7:0] exp_seg [4];
        logic [3:0] exp_sel;
        int slot;
        int p;
        exp_seg[0] = e0;
        exp_seg[1] = e1;
        exp_seg[2] = e2;
        exp_seg[3] = e3;
        for (int j = 0; j < 16; j++) begin
            if (j == load_at) begin
                applyStimulus(1'b1, ld, ldot);
            end
            step();
            load = 1'b0;
            slot = j / 4;
            p    = j % 4;
            if (j == load_at) begin
                checkOutput($sformatf("%s pending after load", name), 16'(pending), 16'h1);
            end
            if (j == 0) begin
                checkOutput($sformatf("%s frame_start low", name), 16'(frame_start), 16'h0);
            end
            exp_sel = (p == 0) ? 4'b1111 : ~(4'b0001 << slot);
            checkOutput($sformatf("%s sel c%0d", name, j), 16'(digit_sel), 16'(exp_sel));
            if (p != 0) begin
                checkOutput($sformatf("%s seg c%0d", name, j), 16'(seg), 16'(exp_seg[slot]));
            end
        end
    endtask

    initial begin
        // Reset state with the clock running.
        repeat (3) step();
        checkOutput("reset seg", 16'(seg), 16'h00FF);
        checkOutput("reset sel", 16'(digit_sel), 16'h000F);
        checkOutput("reset pending", 16'(pending), 16'h0);
        checkOutput("reset frame_start", 16'(frame_start), 16'h0);

        // Release, enable and load 1234 on the first edge.
        rst_n  = 1'b1;
        enable = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'h0);
        step();
        load = 1'b0;
        checkOutput("first load pending", 16'(pending), 16'h1);
        checkOutput("first slot dark", 16'(digit_sel), 16'h000F);
        repeat (15) step();
        checkOutput("wrap0 frame_start", 16'(frame_start), 16'h1);
        checkOutput("wrap0 pending", 16'(pending), 16'h0);

        // 1234 shown; AAAA loaded mid-frame must not tear it.
        runFrame("f1234", 8'h99, 8'hB0, 8'hA4, 8'hF9, 6, 16'hAAAA, 4'h0);
        checkOutput("wrapA frame_start", 16'(frame_start), 16'h1);
        checkOutput("wrapA pending", 16'(pending), 16'h0);

        // AAAA shown; 0F0F loaded on a wrap with nothing pending.
        runFrame("fAAAA", 8'h88, 8'h88, 8'h88, 8'h88, 15, 16'h0F0F, 4'h0);
        checkOutput("wrapB no pulse", 16'(frame_start), 16'h0);
        checkOutput("wrapB pending", 16'(pending), 16'h1);

        // Still AAAA; 5555 loaded exactly on the wrap while 0F0F is pending.
        runFrame("fAAAA2", 8'h88, 8'h88, 8'h88, 8'h88, 15, 16'h5555, 4'h0);
        checkOutput("wrapC frame_start", 16'(frame_start), 16'h1);
        checkOutput("wrapC pending stays", 16'(pending), 16'h1);

        runFrame("f0F0F", 8'h8E, 8'hC0, 8'h8E, 8'hC0, -1, 16'h0000, 4'h0);
        checkOutput("wrapD frame_start", 16'(frame_start), 16'h1);
        checkOutput("wrapD pending", 16'(pending), 16'h0);

        // 5555 shown with blanking on (no effect); then 0050 with dot on digit 2.
        blank_lz = 1'b1;
        runFrame("f5555", 8'h92, 8'h92, 8'h92, 8'h92, 8, 16'h0050, 4'b0100);
        checkOutput("wrapE frame_start", 16'(frame_start), 16'h1);

        runFrame("f0050", 8'hC0, 8'h92, 8'h40, 8'hFF, 2, 16'h0000, 4'h0);
        checkOutput("wrapF frame_start", 16'(frame_start), 16'h1);

        runFrame("f0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF, -1, 16'h0000, 4'h0);
        checkOutput("wrapG no pulse", 16'(frame_start), 16'h0);
        checkOutput("wrapG pending", 16'(pending), 16'h0);

        // Enable dropped mid-slot: dark next clock, load still accepted, state held.
        repeat (6) step();
        checkOutput("pre-disable sel", 16'(digit_sel), 16'h000D);
        enable = 1'b0;
        applyStimulus(1'b1, 16'h1234, 4'h0);
        step();
        load = 1'b0;
        checkOutput("disable sel", 16'(digit_sel), 16'h000F);
        checkOutput("disable seg", 16'(seg), 16'h00FF);
        checkOutput("disable load pending", 16'(pending), 16'h1);
        repeat (3) step();
        checkOutput("disable hold sel", 16'(digit_sel), 16'h000F);
        blank_lz = 1'b0;
        enable   = 1'b1;
        step();
        checkOutput("resume sel", 16'(digit_sel), 16'h000D);
        checkOutput("resume seg", 16'(seg), 16'h00C0);
        step();
        step();
        checkOutput("resume next slot dark", 16'(digit_sel), 16'h000F);
        step();
        checkOutput("resume digit2 sel", 16'(digit_sel), 16'h000B);
        checkOutput("resume digit2 seg", 16'(seg), 16'h00C0);

        // Asynchronous reset mid-frame with data pending.
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset seg", 16'(seg), 16'h00FF);
        checkOutput("async reset sel", 16'(digit_sel), 16'h000F);
        checkOutput("async reset pending", 16'(pending), 16'h0);
        checkOutput("async reset frame_start", 16'(frame_start), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("restart dark", 16'(digit_sel), 16'h000F);
        step();
        checkOutput("restart digit0 sel", 16'(digit_sel), 16'h000E);
        checkOutput("restart digit0 seg", 16'(seg), 16'h00C0);
        repeat (14) step();
        checkOutput("restart wrap no pulse", 16'(frame_start), 16'h0);
        checkOutput("restart wrap pending", 16'(pending), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
